// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared command, state and error encodings plus default device timing
package mem_pkg;

  typedef enum logic [2:0] {
    CMD_NOP     = 3'b000,
    CMD_ACT     = 3'b001,
    CMD_READ    = 3'b010,
    CMD_WRITE   = 3'b011,
    CMD_PRE     = 3'b100,
    CMD_REFRESH = 3'b101
  } cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_ACTIVATING  = 3'd1,
    ST_ACTIVE      = 3'd2,
    ST_PRECHARGING = 3'd3,
    ST_REFRESHING  = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    ERR_NONE            = 3'd0,
    ERR_NO_ROW          = 3'd1,
    ERR_TIMING          = 3'd2,
    ERR_ROW_MISMATCH    = 3'd3,
    ERR_ACT_OPEN        = 3'd4,
    ERR_ILLEGAL_CMD     = 3'd5,
    ERR_REFRESH_OVERDUE = 3'd6,
    ERR_BUS_CONFLICT    = 3'd7
  } err_t;

  localparam int DEF_ROW_BITS = 4;
  localparam int DEF_COL_BITS = 12;
  localparam int DEF_T_RCD    = 5;
  localparam int DEF_CL       = 2;
  localparam int DEF_T_RP     = 4;
  localparam int DEF_T_RFC    = 5;
  localparam int DEF_T_REFI   = 400;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/mem_device_rd_pipe.sv
// rtl/mem_device_rd_pipe.sv - CL-deep read data pipeline; owns the device side of the DQ bus
module mem_device_rd_pipe #(
  parameter int CL = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic [31:0] push_data,
  output logic        rd_vld,
  inout  wire  [31:0] dq
);

  logic [CL-1:0] vld;
  logic [31:0]   data [CL];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      for (int i = 0; i < CL; i++) data[i] <= '0;
    end else begin
      vld[0]  <= push;
      data[0] <= push_data;
      for (int i = 1; i < CL; i++) begin
        vld[i]  <= vld[i-1];
        data[i] <= data[i-1];
      end
    end
  end

  assign rd_vld = vld[CL-1];
  assign dq     = vld[CL-1] ? data[CL-1] : 32'bz;

endmodule

// File: rtl/mem_device.sv
// rtl/mem_device.sv - single-bank SDRAM-style memory device with protocol violation checking
module mem_device
  import mem_pkg::*;
#(
  parameter int ROW_BITS = DEF_ROW_BITS,
  parameter int COL_BITS = DEF_COL_BITS,
  parameter int T_RCD    = DEF_T_RCD,
  parameter int CL       = DEF_CL,
  parameter int T_RP     = DEF_T_RP,
  parameter int T_RFC    = DEF_T_RFC,
  parameter int T_REFI   = DEF_T_REFI
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cs_n,
  input  logic [2:0]          command,
  input  logic [ROW_BITS-1:0] RA,
  input  logic [COL_BITS-1:0] CA,
  inout  wire  [31:0]         DQ,
  output logic                rd_vld,
  output logic [2:0]          bank_state,
  output logic                row_open,
  output logic [ROW_BITS-1:0] open_row,
  output logic                err_pulse,
  output logic [2:0]          err_code
);

  localparam int ADDR_BITS = ROW_BITS + COL_BITS;
  localparam int TMR_BITS  = $clog2(max3(T_RCD, T_RP, T_RFC) + 1);
  localparam int REF_BITS  = $clog2(T_REFI + 1);

  localparam logic [TMR_BITS-1:0] TMR_RCD  = TMR_BITS'(T_RCD - 1);
  localparam logic [TMR_BITS-1:0] TMR_RP   = TMR_BITS'(T_RP - 1);
  localparam logic [TMR_BITS-1:0] TMR_RFC  = TMR_BITS'(T_RFC - 1);
  localparam logic [REF_BITS-1:0] REF_LAST = REF_BITS'(T_REFI - 1);
  localparam logic [REF_BITS-1:0] REF_MAX  = REF_BITS'(T_REFI);

  state_t              state;
  logic [TMR_BITS-1:0] tmr;
  logic [REF_BITS-1:0] ref_cnt;
  err_t                err_q;

  cmd_t       cmd;
  logic       illegal;
  logic       row_hit;
  logic       act_ok, rd_ok, wr_ok, pre_ok, ref_ok;
  logic [7:1] viol;
  err_t       viol_code;
  logic       tmr_last;
  logic [TMR_BITS-1:0] tmr_dec;

  logic [31:0] mem [2**ADDR_BITS];
  logic [31:0] rd_word;

  // Each violation sets its own bit; only commands with no bit set in their
  // own state branch produce an *_ok strobe, so violations never act.
  always_comb begin
    cmd     = cs_n ? CMD_NOP : cmd_t'(command);
    illegal = !cs_n && (command[2:1] == 2'b11);
    row_hit = (RA == open_row);
    act_ok  = 1'b0;
    rd_ok   = 1'b0;
    wr_ok   = 1'b0;
    pre_ok  = 1'b0;
    ref_ok  = 1'b0;
    viol    = '0;
    viol[ERR_ILLEGAL_CMD] = illegal;
    case (state)
      ST_IDLE: begin
        act_ok = (cmd == CMD_ACT);
        ref_ok = (cmd == CMD_REFRESH);
        viol[ERR_NO_ROW] = (cmd == CMD_READ) || (cmd == CMD_WRITE);
      end
      ST_ACTIVATING: begin
        pre_ok = (cmd == CMD_PRE);
        viol[ERR_TIMING]   = (cmd != CMD_NOP) && (cmd != CMD_PRE);
        viol[ERR_ACT_OPEN] = (cmd == CMD_ACT);
      end
      ST_ACTIVE: begin
        pre_ok = (cmd == CMD_PRE);
        viol[ERR_ACT_OPEN]     = (cmd == CMD_ACT) || (cmd == CMD_REFRESH);
        viol[ERR_ROW_MISMATCH] = ((cmd == CMD_READ) || (cmd == CMD_WRITE)) && !row_hit;
        viol[ERR_BUS_CONFLICT] = (cmd == CMD_WRITE) && rd_vld;
        rd_ok = (cmd == CMD_READ) && row_hit;
        wr_ok = (cmd == CMD_WRITE) && row_hit && !rd_vld;
      end
      ST_PRECHARGING: begin
        viol[ERR_TIMING] = (cmd != CMD_NOP);
        viol[ERR_NO_ROW] = (cmd == CMD_READ) || (cmd == CMD_WRITE);
      end
      default: viol[ERR_TIMING] = (cmd != CMD_NOP);
    endcase
    viol[ERR_REFRESH_OVERDUE] = (ref_cnt == REF_LAST) && !ref_ok;
    viol_code = ERR_NONE;
    for (int i = 7; i >= 1; i--) begin
      if (viol[i]) viol_code = err_t'(i[2:0]);
    end
  end

  // Timed states leave on the edge where tmr reaches 0, so a load of T-1
  // makes the next command legal exactly T cycles after the one that started it.
  assign tmr_last = (tmr <= TMR_BITS'(1));
  assign tmr_dec  = (tmr == '0) ? '0 : tmr - TMR_BITS'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      tmr      <= '0;
      ref_cnt  <= '0;
      row_open <= 1'b0;
      open_row <= '0;
      err_q    <= ERR_NONE;
    end else begin
      if (err_q == ERR_NONE && viol != '0) err_q <= viol_code;

      if (ref_ok)                ref_cnt <= '0;
      else if (ref_cnt != REF_MAX) ref_cnt <= ref_cnt + REF_BITS'(1);

      case (state)
        ST_IDLE: begin
          if (act_ok) begin
            open_row <= RA;
            row_open <= 1'b1;
            tmr      <= TMR_RCD;
            state    <= ST_ACTIVATING;
          end else if (ref_ok) begin
            tmr   <= TMR_RFC;
            state <= ST_REFRESHING;
          end
        end
        ST_ACTIVATING: begin
          if (pre_ok) begin
            row_open <= 1'b0;
            tmr      <= TMR_RP;
            state    <= ST_PRECHARGING;
          end else begin
            tmr <= tmr_dec;
            if (tmr_last) state <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (pre_ok) begin
            row_open <= 1'b0;
            tmr      <= TMR_RP;
            state    <= ST_PRECHARGING;
          end
        end
        default: begin
          tmr <= tmr_dec;
          if (tmr_last) state <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[{RA, CA}] <= DQ;
  end

  assign rd_word = mem[{RA, CA}];

  mem_device_rd_pipe #(
    .CL(CL)
  ) u_rd_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (rd_ok),
    .push_data(rd_word),
    .rd_vld   (rd_vld),
    .dq       (DQ)
  );

  assign bank_state = state;
  assign err_code   = err_q;
  assign err_pulse  = rst_n && (viol != '0);

endmodule

// File: tb/tb_mem_device.sv
// tb/tb_mem_device.sv - directed self-checking bench for mem_device
module tb_mem_device;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cs_n;
  logic [2:0]  command;
  logic [3:0]  RA;
  logic [11:0] CA;
  logic        tb_oe;
  logic [31:0] tb_dq;
  wire  [31:0] DQ;
  logic        rd_vld;
  logic [2:0]  bank_state;
  logic        row_open;
  logic [3:0]  open_row;
  logic        err_pulse;
  logic [2:0]  err_code;

  int checks = 0;
  int failures = 0;

  assign DQ = tb_oe ? tb_dq : 32'bz;

  always #5 clk = ~clk;

  mem_device dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cs_n      (cs_n),
    .command   (command),
    .RA        (RA),
    .CA        (CA),
    .DQ        (DQ),
    .rd_vld    (rd_vld),
    .bank_state(bank_state),
    .row_open  (row_open),
    .open_row  (open_row),
    .err_pulse (err_pulse),
    .err_code  (err_code)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are observed 1ns later, mid-cycle.
  task automatic step(input logic [2:0] c, input logic [3:0] ra, input logic [11:0] ca,
                      input logic oe, input logic [31:0] d);
    @(negedge clk);
    cs_n = 1'b0; command = c; RA = ra; CA = ca; tb_oe = oe; tb_dq = d;
    #1;
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) step(CMD_NOP, 4'd0, 12'd0, 1'b0, 32'd0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; cs_n = 1'b1; command = CMD_NOP; tb_oe = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; cs_n = 1'b1; command = CMD_NOP; RA = '0; CA = '0; tb_oe = 1'b0; tb_dq = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_state", bank_state, ST_IDLE);
    chk("rst_row_open", row_open, 0);
    chk("rst_rd_vld", rd_vld, 0);
    chk("rst_err_pulse", err_pulse, 0);
    chk("rst_err_code", err_code, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // write / read-back, back-to-back reads, read data surviving a PRE
    step(CMD_ACT, 4'd3, 12'h000, 1'b0, 32'd0);
    nop(4);
    chk("act_state_t4", bank_state, ST_ACTIVATING);
    chk("act_open_row", open_row, 3);
    chk("act_row_open", row_open, 1);
    step(CMD_WRITE, 4'd3, 12'h010, 1'b1, 32'hDEADBEEF);
    chk("act_state_t5", bank_state, ST_ACTIVE);
    chk("wr_t5_no_err", err_pulse, 0);
    step(CMD_READ, 4'd3, 12'h010, 1'b0, 32'd0);
    chk("rd_t6_no_vld", rd_vld, 0);
    step(CMD_WRITE, 4'd3, 12'h011, 1'b1, 32'hCAFEF00D);
    chk("wr_t7_no_err", err_pulse, 0);
    step(CMD_READ, 4'd3, 12'h011, 1'b0, 32'd0);
    chk("rd_t8_vld", rd_vld, 1);
    chk("rd_t8_data", DQ, 32'hDEADBEEF);
    step(CMD_READ, 4'd3, 12'h010, 1'b1, 32'h0F0F0F0F);
    chk("t9_no_vld", rd_vld, 0);
    chk("t9_dq_released", DQ, 32'h0F0F0F0F);
    step(CMD_PRE, 4'd0, 12'h000, 1'b0, 32'd0);
    chk("b2b_vld", rd_vld, 1);
    chk("b2b_data", DQ, 32'hCAFEF00D);
    nop(1);
    chk("pre_rd_vld", rd_vld, 1);
    chk("pre_rd_data", DQ, 32'hDEADBEEF);
    chk("pre_state", bank_state, ST_PRECHARGING);
    chk("pre_row_open", row_open, 0);
    nop(1);
    chk("t12_no_vld", rd_vld, 0);
    nop(1);
    chk("pre_state_t3", bank_state, ST_PRECHARGING);
    nop(1);
    chk("pre_idle_t4", bank_state, ST_IDLE);
    chk("t1_err_code", err_code, 0);

    // command too early during ACTIVATING
    step(CMD_ACT, 4'd5, 12'h000, 1'b0, 32'd0);
    nop(2);
    step(CMD_READ, 4'd5, 12'h000, 1'b0, 32'd0);
    chk("trcd_pulse", err_pulse, 1);
    nop(1);
    chk("trcd_code", err_code, ERR_TIMING);
    chk("trcd_pulse_once", err_pulse, 0);
    nop(1);
    chk("trcd_no_vld_a", rd_vld, 0);
    chk("trcd_active", bank_state, ST_ACTIVE);
    nop(1);
    chk("trcd_no_vld_b", rd_vld, 0);
    step(CMD_READ, 4'd4, 12'h000, 1'b0, 32'd0);
    chk("mismatch_pulse", err_pulse, 1);

    // sticky first error code
    apply_reset();
    step(CMD_READ, 4'd1, 12'h000, 1'b0, 32'd0);
    chk("norow_pulse", err_pulse, 1);
    nop(1);
    chk("norow_code", err_code, ERR_NO_ROW);
    step(CMD_ACT, 4'd2, 12'h000, 1'b0, 32'd0);
    chk("act_idle_ok", err_pulse, 0);
    nop(4);
    step(CMD_ACT, 4'd6, 12'h000, 1'b0, 32'd0);
    chk("actopen_state", bank_state, ST_ACTIVE);
    chk("actopen_pulse", err_pulse, 1);
    nop(1);
    chk("actopen_sticky", err_code, ERR_NO_ROW);
    chk("actopen_row", open_row, 2);
    step(3'b110, 4'd2, 12'h000, 1'b0, 32'd0);
    chk("illegal_pulse", err_pulse, 1);
    @(negedge clk);
    cs_n = 1'b1; command = CMD_ACT; RA = 4'd9;
    #1;
    chk("desel_no_err", err_pulse, 0);

    // WRITE while read data is on the bus
    apply_reset();
    step(CMD_ACT, 4'd3, 12'h000, 1'b0, 32'd0);
    nop(4);
    step(CMD_READ, 4'd3, 12'h010, 1'b0, 32'd0);
    nop(1);
    step(CMD_WRITE, 4'd3, 12'h011, 1'b0, 32'd0);
    chk("conflict_vld", rd_vld, 1);
    chk("conflict_pulse", err_pulse, 1);
    nop(1);
    chk("conflict_code", err_code, ERR_BUS_CONFLICT);
    step(CMD_READ, 4'd3, 12'h011, 1'b0, 32'd0);
    nop(2);
    chk("conflict_mem_vld", rd_vld, 1);
    chk("conflict_mem_kept", DQ, 32'hCAFEF00D);

    // refresh overdue, refresh timing, reset during REFRESHING
    apply_reset();
    nop(398);
    step(CMD_NOP, 4'd0, 12'h000, 1'b0, 32'd0);
    chk("refi_pulse", err_pulse, 1);
    chk("refi_code_before", err_code, 0);
    nop(1);
    chk("refi_code", err_code, ERR_REFRESH_OVERDUE);
    chk("refi_pulse_clear", err_pulse, 0);
    nop(1);
    chk("refi_once", err_pulse, 0);
    step(CMD_REFRESH, 4'd0, 12'h000, 1'b0, 32'd0);
    chk("ref_legal", err_pulse, 0);
    nop(4);
    chk("ref_busy", bank_state, ST_REFRESHING);
    nop(1);
    chk("ref_done", bank_state, ST_IDLE);
    step(CMD_ACT, 4'd7, 12'h000, 1'b0, 32'd0);
    nop(4);
    step(CMD_PRE, 4'd0, 12'h000, 1'b0, 32'd0);
    nop(3);
    step(CMD_REFRESH, 4'd0, 12'h000, 1'b0, 32'd0);
    chk("ref2_legal", err_pulse, 0);
    nop(1);
    chk("ref2_state", bank_state, ST_REFRESHING);
    chk("ref2_open_row", open_row, 7);
    #2;
    rst_n = 1'b0; cs_n = 1'b1; tb_oe = 1'b0;
    #1;
    chk("midrst_state", bank_state, ST_IDLE);
    chk("midrst_row_open", row_open, 0);
    chk("midrst_open_row", open_row, 0);
    chk("midrst_rd_vld", rd_vld, 0);
    chk("midrst_err_pulse", err_pulse, 0);
    chk("midrst_err_code", err_code, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(CMD_ACT, 4'd3, 12'h000, 1'b0, 32'd0);
    nop(4);
    step(CMD_READ, 4'd3, 12'h010, 1'b0, 32'd0);
    nop(2);
    chk("post_rst_vld", rd_vld, 1);
    chk("post_rst_data", DQ, 32'hDEADBEEF);
    chk("post_rst_code", err_code, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
